// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing -- 640x480@60 style VGA timing generator with a two-stage output
// pipeline.
//
// Stage A (x, y, video_active, frame_start, frame_count) is registered from
// the *next* counter values, so x/y always describe the pixel that the
// counters currently point at. Stage B (vga_rgb, vga_hsync, vga_vsync) is
// registered one clock later from stage A, so colour (looked up
// combinationally from x/y by the image generator) and sync stay aligned.
//
// Ports:
//   CLOCK_25      in   1  pixel clock, rising edge
//   RESET         in   1  asynchronous, active-high reset
//   color_in      in   3  pixel colour for current x/y {r,g,b}
//   test_pattern  in   1  (only with VGA_TEST_PATTERN_EN) colour-bar select
//   x, y          out 12  1-based visible pixel column/row, 0 when blanked
//   video_active  out  1  x/y lie in the visible area
//   frame_start   out  1  one-clock pulse at x=1, y=1
//   frame_count   out 16  frames started since reset (wraps)
//   vga_rgb       out  3  colour to the DAC
//   vga_hsync     out  1  horizontal sync, active low
//   vga_vsync     out  1  vertical sync, active low
//
// Optional feature macro: VGA_TEST_PATTERN_EN adds the test_pattern input
// and an eight-bar colour generator (bars are 80 pixels wide).
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        CLOCK_25,
    input  logic        RESET,
    input  logic [2:0]  color_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        video_active,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic [2:0]  vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    // Last count value of each phase; 12-bit counters cover totals to 4095.
    localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FP_LAST  = 12'(H_ACTIVE + H_FRONT - 1);
    localparam logic [11:0] H_SYN_LAST = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] H_TOT_LAST = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FP_LAST  = 12'(V_ACTIVE + V_FRONT - 1);
    localparam logic [11:0] V_SYN_LAST = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [11:0] V_TOT_LAST = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SYN = 2'd2, H_BP = 2'd3} h_state_e;
    typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SYN = 2'd2, V_BP = 2'd3} v_state_e;

    h_state_e    h_state_q, h_state_d;
    v_state_e    v_state_q, v_state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        h_wrap_s;

    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        video_active_q, video_active_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [2:0]  vga_rgb_q, vga_rgb_d;
    logic        vga_hsync_q, vga_hsync_d;
    logic        vga_vsync_q, vga_vsync_d;

    // State register: counters, FSMs and both output stages.
    // Reset parks everything on the last count so the first edge after
    // release lands on pixel (1,1) and raises frame_start.
    always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
            h_state_q      <= H_BP;
            v_state_q      <= V_BP;
            h_cnt_q        <= H_TOT_LAST;
            v_cnt_q        <= V_TOT_LAST;
            x_q            <= 12'd0;
            y_q            <= 12'd0;
            video_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_count_q  <= 16'd0;
            vga_rgb_q      <= 3'b000;
            vga_hsync_q    <= 1'b1;
            vga_vsync_q    <= 1'b1;
        end else begin
            h_state_q      <= h_state_d;
            v_state_q      <= v_state_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            video_active_q <= video_active_d;
            frame_start_q  <= frame_start_d;
            frame_count_q  <= frame_count_d;
            vga_rgb_q      <= vga_rgb_d;
            vga_hsync_q    <= vga_hsync_d;
            vga_vsync_q    <= vga_vsync_d;
        end
    end

    // Next-state logic: counters and the two phase FSMs.
    // The vertical side only moves on the end-of-line wrap.
    always_comb begin
        h_wrap_s  = (h_cnt_q == H_TOT_LAST);
        h_cnt_d   = h_wrap_s ? 12'd0 : (h_cnt_q + 12'd1);
        v_cnt_d   = v_cnt_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;

        if (h_wrap_s) begin
            v_cnt_d = (v_cnt_q == V_TOT_LAST) ? 12'd0 : (v_cnt_q + 12'd1);
        end else begin
            v_cnt_d = v_cnt_q;
        end

        case (h_state_q)
            H_ACT:   h_state_d = (h_cnt_q == H_ACT_LAST) ? H_FP  : H_ACT;
            H_FP:    h_state_d = (h_cnt_q == H_FP_LAST)  ? H_SYN : H_FP;
            H_SYN:   h_state_d = (h_cnt_q == H_SYN_LAST) ? H_BP  : H_SYN;
            H_BP:    h_state_d = (h_cnt_q == H_TOT_LAST) ? H_ACT : H_BP;
            default: h_state_d = H_BP;
        endcase

        if (h_wrap_s) begin
            case (v_state_q)
                V_ACT:   v_state_d = (v_cnt_q == V_ACT_LAST) ? V_FP  : V_ACT;
                V_FP:    v_state_d = (v_cnt_q == V_FP_LAST)  ? V_SYN : V_FP;
                V_SYN:   v_state_d = (v_cnt_q == V_SYN_LAST) ? V_BP  : V_SYN;
                V_BP:    v_state_d = (v_cnt_q == V_TOT_LAST) ? V_ACT : V_BP;
                default: v_state_d = V_BP;
            endcase
        end else begin
            v_state_d = v_state_q;
        end
    end

    // Output logic: stage A from the next counter/FSM values, stage B from
    // the current stage A so colour and sync leave together.
    always_comb begin
        video_active_d = (h_state_d == H_ACT) && (v_state_d == V_ACT);
        x_d            = video_active_d ? (h_cnt_d + 12'd1) : 12'd0;
        y_d            = video_active_d ? (v_cnt_d + 12'd1) : 12'd0;
        frame_start_d  = (h_cnt_d == 12'd0) && (v_cnt_d == 12'd0);
        frame_count_d  = frame_count_q + {15'd0, frame_start_d};

        vga_hsync_d    = (h_state_q != H_SYN);
        vga_vsync_d    = (v_state_q != V_SYN);

        if (video_active_q) begin
`ifdef VGA_TEST_PATTERN_EN
            // Bar index 0..7 from x; white bar first, black last.
            if (test_pattern) begin
                vga_rgb_d = 3'd7 - 3'((x_q - 12'd1) / 12'd80);
            end else begin
                vga_rgb_d = color_in;
            end
`else
            vga_rgb_d = color_in;
`endif
        end else begin
            vga_rgb_d = 3'b000;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign video_active = video_active_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;
    assign vga_rgb      = vga_rgb_q;
    assign vga_hsync    = vga_hsync_q;
    assign vga_vsync    = vga_vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing -- scoreboard bench for vga_timing.
// Horizontal timing is the full 800-clock line; the vertical frame is
// shortened to 12/2/2/4 lines (20 lines, 16000 clocks per frame) to keep the
// run short. Expected values are hand-computed; "cycle k" means the state
// after the k-th rising edge following reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  color_in;
    logic [11:0] x, y;
    logic        video_active, frame_start;
    logic [15:0] frame_count;
    logic [2:0]  vga_rgb;
    logic        vga_hsync, vga_vsync;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    vga_timing #(
        .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(12),  .V_FRONT(2),  .V_SYNC(2),  .V_BACK(4)
    ) dut (
        .CLOCK_25     (clk),
        .RESET        (rst),
        .color_in     (color_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .x            (x),
        .y            (y),
        .video_active (video_active),
        .frame_start  (frame_start),
        .frame_count  (frame_count),
        .vga_rgb      (vga_rgb),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync)
    );

    always #20 clk = ~clk;

    // Image generator: bit2 always set, so active colour is never 000; x=1 gives 101.
    assign color_in = {1'b1, x[1:0]};

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   phase = 0;

    int hs_low = 0, x_zero = 0, rgb_zero = 0, vs_low = 0, ymax = 0, fs_n = 0;
    int fs_at[3];

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic int sig_val(int s);
        case (s)
            0: return int'(x);
            1: return int'(y);
            2: return int'(video_active);
            3: return int'(frame_start);
            4: return int'(frame_count);
            5: return int'(vga_rgb);
            6: return int'(vga_hsync);
            7: return int'(vga_vsync);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            0: return "x";
            1: return "y";
            2: return "video_active";
            3: return "frame_start";
            4: return "frame_count";
            5: return "vga_rgb";
            6: return "vga_hsync";
            7: return "vga_vsync";
            default: return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int c, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_va"}, int'(video_active), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
        check({tag, "_fc"}, int'(frame_count), 0);
        check({tag, "_rgb"}, int'(vga_rgb), 0);
        check({tag, "_hs"}, int'(vga_hsync), 1);
        check({tag, "_vs"}, int'(vga_vsync), 1);
        check({tag, "_hcnt"}, int'(dut.h_cnt_q), 799);
        check({tag, "_vcnt"}, int'(dut.v_cnt_q), 19);
    endtask

    task automatic push_first_pixel();
        push(1, 0, 1); push(1, 1, 1); push(1, 2, 1); push(1, 3, 1);
        push(1, 4, 1); push(1, 5, 0); push(1, 6, 1); push(1, 7, 1);
        push(2, 5, 5); push(2, 0, 2); push(2, 3, 0); push(2, 4, 1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops every expectation due this cycle and tallies line/frame stats.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    if (sb_q[0].cyc == cyc) begin
                        check($sformatf("%s@%0d", sig_name(sb_q[0].sig), cyc),
                              sig_val(sb_q[0].sig), sb_q[0].val);
                    end else begin
                        check("missed_expectation_cycle", cyc, sb_q[0].cyc);
                    end
                    void'(sb_q.pop_front());
                end
                if (phase == 1) begin
                    if (cyc >= 1 && cyc <= 800 && !vga_hsync) hs_low++;
                    if (cyc >= 1 && cyc <= 800 && x == 12'd0) x_zero++;
                    if (cyc >= 2 && cyc <= 801 && vga_rgb == 3'd0) rgb_zero++;
                    if (cyc >= 1 && cyc <= 16000 && !vga_vsync) vs_low++;
                    if (int'(y) > ymax) ymax = int'(y);
                    if (frame_start) begin
                        if (fs_n < 3) fs_at[fs_n] = cyc;
                        fs_n++;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("rst_init");

        // Phase 1: two and a bit frames from a clean reset.
        push_first_pixel();
        push(640, 0, 640);   push(640, 2, 1);
        push(641, 0, 0);     push(641, 1, 0);   push(641, 2, 0);  push(641, 5, 4);
        push(642, 5, 0);
        push(657, 6, 1);     push(658, 6, 0);   push(753, 6, 0);  push(754, 6, 1);
        push(801, 0, 1);     push(801, 1, 2);   push(801, 3, 0);
        push(802, 5, 5);
        push(9440, 0, 640);  push(9440, 1, 12);
        push(9441, 0, 0);    push(9441, 1, 0);
        push(11201, 7, 1);   push(11202, 7, 0); push(12801, 7, 0); push(12802, 7, 1);
        push(16000, 3, 0);   push(16000, 0, 0);
        push(16001, 3, 1);   push(16001, 4, 2); push(16001, 0, 1); push(16001, 1, 1);
        push(32001, 3, 1);   push(32001, 4, 3);
        push(32700, 6, 0);
        phase  = 1;
        mon_en = 1'b1;
        rst    = 1'b0;

        // Reset in the middle of an hsync pulse (h_cnt=700 at cycle 32701).
        wait_cyc(32701);
        #1 rst = 1'b1;
        phase = 2;
        #1 reset_checks("rst_mid");
        check("sb_drain_phase1", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        reset_checks("rst_hold");

        // Phase 2: restart sequence, frame_count wrap via force, optional bars.
        push_first_pixel();
        push(101, 4, 65535);
`ifdef VGA_TEST_PATTERN_EN
        push(802, 5, 7);  push(881, 5, 7);  push(882, 5, 6);
        push(961, 5, 6);  push(1362, 5, 0); push(1441, 5, 0);
`endif
        push(1500, 4, 65535);
        push(16000, 4, 65535); push(16000, 3, 0);
        push(16001, 3, 1);     push(16001, 4, 0);
        push(16001, 0, 1);     push(16001, 1, 1);
        rst = 1'b0;

        wait_cyc(100);
        #1 force dut.frame_count_q = 16'hFFFF;
        #1 release dut.frame_count_q;
`ifdef VGA_TEST_PATTERN_EN
        wait_cyc(800);
        #1 test_pattern = 1'b1;
        wait_cyc(1441);
        #1 test_pattern = 1'b0;
`endif
        wait_cyc(16002);
        check("sb_drain_phase2", sb_q.size(), 0);

        check("hsync_low_per_line", hs_low, 96);
        check("x_zero_per_line", x_zero, 160);
        check("rgb_zero_per_line", rgb_zero, 160);
        check("vsync_low_per_frame", vs_low, 1600);
        check("y_max", ymax, 12);
        check("frame_start_count", fs_n, 3);
        if (fs_n >= 3) begin
            check("frame_interval_1", fs_at[1] - fs_at[0], 16000);
            check("frame_interval_2", fs_at[2] - fs_at[1], 16000);
        end else begin
            check("frame_interval_available", fs_n, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
